// File: rtl/rs_enc_lfsr_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_enc_lfsr_if
// Description : Symbol stream bundle for the Reed-Solomon encoder.
//               Carries the message-side valid/ready handshake, the
//               output-side valid/ready handshake with parity/last markers,
//               and the length-error pulse.
//               master : upstream/downstream environment
//                        (drives in_valid, in_data, in_last, out_ready)
//               slave  : the encoder
//                        (drives in_ready, out_valid, out_data, out_parity,
//                         out_last, len_err)
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_enc_lfsr_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_parity;
  logic       out_last;
  logic       out_ready;
  logic       len_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_last, len_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_last, len_err
  );
endinterface
`default_nettype wire

// File: rtl/rs_enc_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : rs_enc_lfsr
// Description : Systematic Reed-Solomon encoder over GF(2^8). Message symbols
//               pass straight to the output register; after the last message
//               symbol (or the K-th) the N_PARITY remainder symbols of
//               M(x)*x^N_PARITY mod g(x) follow, highest degree first.
//               g(x) = prod_{i=0}^{N_PARITY-1} (x - alpha^(FCR+i)), alpha=0x02,
//               computed at elaboration.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - rs_enc_lfsr_if.slave: in_valid/in_data/in_last/in_ready
//                      message side; out_valid/out_data/out_parity/out_last/
//                      out_ready output side; len_err one-cycle pulse when K
//                      symbols were accepted without in_last
// Revision    : 1.0 - initial release
// ============================================================================
module rs_enc_lfsr #(
  parameter int         N_PARITY  = 16,
  parameter int         K         = 239,
  parameter logic [8:0] PRIM_POLY = 9'h11D,
  parameter int         FCR       = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  rs_enc_lfsr_if.slave     bus
);

  localparam int CNT_W  = $clog2(K + 1);
  localparam int PCNT_W = $clog2(N_PARITY + 1);

  // GF(2^8) multiply, shift-and-add with reduction by PRIM_POLY.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? PRIM_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

  // Expand the product of (x + alpha^(FCR+i)) one root at a time. Coefficient
  // j lives in byte j; the monic leading term is dropped on return.
  function automatic logic [8*N_PARITY-1:0] gen_poly();
    logic [8*N_PARITY+7:0] g;
    logic [7:0]            root;
    g        = '0;
    g[7:0]   = 8'h01;
    root     = 8'h01;
    for (int e = 0; e < FCR; e++) root = gf_mul(root, 8'h02);
    for (int i = 0; i < N_PARITY; i++) begin
      for (int j = N_PARITY; j >= 1; j--)
        g[j*8 +: 8] = g[(j-1)*8 +: 8] ^ gf_mul(g[j*8 +: 8], root);
      g[7:0] = gf_mul(g[7:0], root);
      root   = gf_mul(root, 8'h02);
    end
    return g[8*N_PARITY-1:0];
  endfunction

  localparam logic [8*N_PARITY-1:0] c_gen = gen_poly();

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MSG  = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_rem [N_PARITY];
  logic [CNT_W-1:0]    r_msg_cnt;
  logic [PCNT_W-1:0]   r_par_cnt;
  logic                r_out_valid;
  logic [7:0]          r_out_data;
  logic                r_out_parity;
  logic                r_out_last;
  logic                r_len_err;

  logic                w_out_free;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_kth;
  logic                w_msg_end;
  logic                w_par_load;
  logic                w_par_end;
  logic [7:0]          w_fb;
  logic [7:0]          w_fb_prod [N_PARITY];

  // Feedback times each generator coefficient; the coefficients are
  // constants, so each product reduces to a fixed XOR network.
  assign w_fb = bus.in_data ^ r_rem[N_PARITY-1];

  for (genvar gi = 0; gi < N_PARITY; gi++) begin : g_tap
    assign w_fb_prod[gi] = gf_mul(w_fb, c_gen[gi*8 +: 8]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_out_free  = !r_out_valid || bus.out_ready;
    // Held low during reset so nothing is accepted while state is cleared.
    w_in_ready  = !rst && (r_state != S_PAR) && w_out_free;
    w_accept    = bus.in_valid && w_in_ready;
    w_kth       = (r_msg_cnt == CNT_W'(K - 1));
    w_msg_end   = w_accept && (bus.in_last || w_kth);
    w_par_load  = (r_state == S_PAR) && w_out_free;
    w_par_end   = w_par_load && (r_par_cnt == PCNT_W'(N_PARITY - 1));
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = w_msg_end ? S_PAR : S_MSG;
      S_MSG:   if (w_msg_end) w_state_nxt = S_PAR;
      S_PAR:   if (w_par_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PARITY; i++) r_rem[i] <= 8'h00;
      r_msg_cnt    <= '0;
      r_par_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_parity <= 1'b0;
      r_out_last   <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_len_err <= w_accept && w_kth && !bus.in_last;
      if (w_accept) begin
        r_rem[0] <= w_fb_prod[0];
        for (int i = 1; i < N_PARITY; i++) r_rem[i] <= r_rem[i-1] ^ w_fb_prod[i];
        r_msg_cnt    <= w_msg_end ? '0 : r_msg_cnt + CNT_W'(1);
        r_out_valid  <= 1'b1;
        r_out_data   <= bus.in_data;
        r_out_parity <= 1'b0;
        r_out_last   <= 1'b0;
      end else if (w_par_load) begin
        // Shifting zeros in leaves the remainder clear once parity is done.
        r_rem[0] <= 8'h00;
        for (int i = 1; i < N_PARITY; i++) r_rem[i] <= r_rem[i-1];
        r_par_cnt    <= w_par_end ? '0 : r_par_cnt + PCNT_W'(1);
        r_out_valid  <= 1'b1;
        r_out_data   <= r_rem[N_PARITY-1];
        r_out_parity <= 1'b1;
        r_out_last   <= w_par_end;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_parity = r_out_parity;
  assign bus.out_last   = r_out_last;
  assign bus.len_err    = r_len_err;

endmodule
`default_nettype wire

// File: doc/rs_enc_lfsr.md
# rs_enc_lfsr

Parametrised systematic Reed-Solomon encoder over GF(2^8): a message stream of up to K symbols passes through unchanged and is followed by N_PARITY parity symbols. Parity is the remainder of the message polynomial times x^N_PARITY divided by g(x) = prod(x − α^(FCR+i)) for i = 0..N_PARITY−1. The block generalises the single-tap constant-multiply/XOR stage of the existing RS datapath into a complete encoder with these features:
- an elaboration-time computed generator polynomial;
- a configurable parity count and field polynomial;
- a framing state machine;
- valid/ready handshakes on both sides.

It sits between the framer and the modulator-side symbol path.

## Interface
- N_PARITY, 16: parity symbols per codeword; even, 2..32.
- K, 239: maximum message symbols; K + N_PARITY ≤ 255.
- PRIM_POLY, 9'h11D: GF(2^8) field polynomial; α = 0x02.
- FCR, 0: first consecutive root exponent.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  message symbol valid.
- in_data  input  8  message symbol.
- in_last  input  1  marks last message symbol of a codeword.
- in_ready  output  1  encoder accepts a symbol this cycle.
- out_valid  output  1  output symbol valid.
- out_data  output  8  message or parity symbol.
- out_parity  output  1  current output symbol is parity.
- out_last  output  1  last parity symbol of the codeword.
- out_ready  input  1  downstream accepts the output symbol.
- len_err  output  1  one-cycle pulse: K symbols accepted without in_last.

## Operation
- Generator coefficients g_0..g_{N_PARITY−1}:
  - computed by a constant function at elaboration (monic; g_{N_PARITY} = 1 is implicit);
  - multiplication is by constant GF multipliers reduced by PRIM_POLY.
- Remainder registers r[0..N_PARITY−1], each 8 bits.
- States:
  - IDLE: r all zero, count zero; waiting for the first symbol.
  - MSG: accepting message symbols.
  - PAR: emitting parity.
- Accept event: in_valid && in_ready.
  - fb = in_data ^ r[N_PARITY−1].
  - r[i] <= r[i−1] ^ (fb·g_i) for i ≥ 1.
  - r[0] <= fb·g_0.
  - The symbol is copied to the output register with out_parity = 0.
  - In IDLE, an accept moves the state to MSG.
- Entering PAR:
  - An accept with in_last = 1, or the K-th accept, moves to PAR regardless of state.
  - If the K-th accept has in_last = 0, len_err pulses for one cycle. Further input is then treated as a new codeword.
- PAR, each cycle the output register is free:
  - out_data <= r[N_PARITY−1], out_parity <= 1.
  - r shifts up: r[i] <= r[i−1], r[0] <= 0.
  - The parity counter increments.
  - On the N_PARITY-th parity symbol, out_last <= 1 and the state returns to IDLE (r is then all zero).
- in_ready = (state != PAR) && (!out_valid || out_ready).
  - A new codeword's first symbol is accepted the cycle after the out_last symbol is loaded, provided the output is free.
- Output register: loads when (!out_valid || out_ready) and there is a symbol to load. out_valid clears when out_ready is high and nothing loads.
- Output stability: out_data, out_parity and out_last hold stable while out_valid && !out_ready.
- Reset mid-codeword: the partial codeword is discarded with no parity emitted. The state returns to IDLE and the remainder is cleared.

## Timing
- Reset values: in_ready 0 while rst is asserted, 1 in the first cycle after release. out_valid 0, out_data 0x00, out_parity 0, out_last 0, len_err 0.
- Latency: one cycle from accept to out_valid for message symbols.
- The first parity symbol is presented one cycle after the last message symbol is consumed downstream.
- Throughput with out_ready held high: one symbol per cycle.
  - A codeword of m message symbols occupies exactly m + N_PARITY output cycles.
  - Input is stalled N_PARITY cycles per codeword.
- in_ready is combinational from state, out_valid and out_ready. No other combinational input-to-output path.
- len_err is asserted in the cycle after the offending accept.

## Test plan
- N_PARITY=2, one symbol 0x01 with in_last -> out 0x01, 0x03 (parity), 0x02 (parity, out_last).
- N_PARITY=2, message 0x01, 0x00 (last on second) -> out 0x01, 0x00, 0x07, 0x06. Message 0x00 alone -> 0x00, 0x00, 0x00.
- Default parameters, 239 random symbols -> the 16 parity symbols match a software RS(255,239) reference. Also check back-to-back codewords with no idle gap and the 16-cycle input stall.
- out_ready randomly toggled (~50 %) during message and parity -> identical symbol sequence. Outputs stable while stalled; no symbol lost or duplicated.
- K=4, N_PARITY=2, six symbols with no in_last -> len_err pulses after the 4th accept. Parity for symbols 1–4 is emitted, then symbols 5–6 start a new codeword.
- rst asserted after 3 message symbols -> outputs reach their reset values immediately. Next codeword 0x01 with in_last yields parity 0x03, 0x02 (N_PARITY=2), proving the remainder was cleared.
